// File: rtl/id_exe_stage.sv
// Decode-to-execute pipeline register for the RV32I integer pipe.
// Selects forwarded operands, detects load-use hazards and latches the EXE-stage payload.
module id_exe_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic [3:0]  dec_alu_opc,
  input  logic        dec_sel_pc,
  input  logic        dec_sel_imm,
  input  logic        dec_is_load,
  input  logic        dec_wen,
  input  logic [31:0] dec_pc,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic [31:0] dec_rs1_data,
  input  logic [31:0] dec_rs2_data,
  input  logic [31:0] dec_imm,
  input  logic [31:0] alu_result,
  input  logic [4:0]  mem_rd,
  input  logic        mem_wen,
  input  logic [31:0] mem_data,
  input  logic        hold,
  input  logic        flush,
  output logic        dec_stall,
  output logic        exe_valid_r,
  output logic [3:0]  exe_alu_opc_r,
  output logic        exe_sel_pc_r,
  output logic [31:0] exe_pc_r,
  output logic [31:0] exe_reg1_r,
  output logic [31:0] exe_src2_r,
  output logic [31:0] exe_store_data_r,
  output logic [4:0]  exe_rd_r,
  output logic        exe_wen_r,
  output logic        exe_is_load_r
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  logic            exe_fwd_ok;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] src2;
  logic            load_use;

  // Operand forwarding: a non-load in EXE beats the MEM stage; x0 always reads the register file.
  always_comb begin
    exe_fwd_ok = exe_valid_r & exe_wen_r & ~exe_is_load_r;
    fwd_rs1    = dec_rs1_data;
    fwd_rs2    = dec_rs2_data;
    if (FWD_EN && (dec_rs1 != RW'(0))) begin
      if (exe_fwd_ok && (exe_rd_r == dec_rs1))  fwd_rs1 = alu_result;
      else if (mem_wen && (mem_rd == dec_rs1))  fwd_rs1 = mem_data;
    end
    if (FWD_EN && (dec_rs2 != RW'(0))) begin
      if (exe_fwd_ok && (exe_rd_r == dec_rs2))  fwd_rs2 = alu_result;
      else if (mem_wen && (mem_rd == dec_rs2))  fwd_rs2 = mem_data;
    end
    src2 = dec_sel_imm ? dec_imm : fwd_rs2;
  end

  // Load in EXE whose result is needed now: its data only exists once it reaches MEM.
  always_comb begin
    load_use  = dec_valid & exe_valid_r & exe_is_load_r & exe_wen_r &
                (exe_rd_r != RW'(0)) &
                ((exe_rd_r == dec_rs1) | (~dec_sel_imm & (exe_rd_r == dec_rs2)));
    dec_stall = hold | load_use;
  end

  // Flush beats hold; a load-use hazard turns the slot into a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_valid_r      <= 1'b0;
      exe_alu_opc_r    <= 4'b0000;
      exe_sel_pc_r     <= 1'b0;
      exe_pc_r         <= '0;
      exe_reg1_r       <= '0;
      exe_src2_r       <= '0;
      exe_store_data_r <= '0;
      exe_rd_r         <= '0;
      exe_wen_r        <= 1'b0;
      exe_is_load_r    <= 1'b0;
    end else if (flush || (!hold && load_use)) begin
      exe_valid_r   <= 1'b0;
      exe_wen_r     <= 1'b0;
      exe_is_load_r <= 1'b0;
    end else if (!hold) begin
      exe_valid_r      <= dec_valid;
      exe_alu_opc_r    <= dec_alu_opc;
      exe_sel_pc_r     <= dec_sel_pc;
      exe_pc_r         <= dec_pc;
      exe_reg1_r       <= fwd_rs1;
      exe_src2_r       <= src2;
      exe_store_data_r <= fwd_rs2;
      exe_rd_r         <= dec_rd;
      exe_wen_r        <= dec_wen & dec_valid;
      exe_is_load_r    <= dec_is_load & dec_valid;
    end
  end

endmodule

// File: tb/tb_id_exe_stage.sv
// Bench for id_exe_stage: directed scenarios then random traffic against a cycle-level reference model.
module tb_id_exe_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid;
  logic [3:0]  dec_alu_opc;
  logic        dec_sel_pc, dec_sel_imm, dec_is_load, dec_wen;
  logic [31:0] dec_pc;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_rs1_data, dec_rs2_data, dec_imm;
  logic [31:0] alu_result;
  logic [4:0]  mem_rd;
  logic        mem_wen;
  logic [31:0] mem_data;
  logic        hold, flush;
  logic        dec_stall;
  logic        exe_valid_r;
  logic [3:0]  exe_alu_opc_r;
  logic        exe_sel_pc_r;
  logic [31:0] exe_pc_r, exe_reg1_r, exe_src2_r, exe_store_data_r;
  logic [4:0]  exe_rd_r;
  logic        exe_wen_r, exe_is_load_r;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model of the EXE register contents
  logic        m_valid, m_sel_pc, m_wen, m_ld;
  logic [3:0]  m_opc;
  logic [31:0] m_pc, m_reg1, m_src2, m_sd;
  logic [4:0]  m_rd;

  id_exe_stage #(.FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_alu_opc(dec_alu_opc),
    .dec_sel_pc(dec_sel_pc), .dec_sel_imm(dec_sel_imm), .dec_is_load(dec_is_load),
    .dec_wen(dec_wen), .dec_pc(dec_pc), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
    .dec_imm(dec_imm), .alu_result(alu_result), .mem_rd(mem_rd), .mem_wen(mem_wen),
    .mem_data(mem_data), .hold(hold), .flush(flush), .dec_stall(dec_stall),
    .exe_valid_r(exe_valid_r), .exe_alu_opc_r(exe_alu_opc_r), .exe_sel_pc_r(exe_sel_pc_r),
    .exe_pc_r(exe_pc_r), .exe_reg1_r(exe_reg1_r), .exe_src2_r(exe_src2_r),
    .exe_store_data_r(exe_store_data_r), .exe_rd_r(exe_rd_r), .exe_wen_r(exe_wen_r),
    .exe_is_load_r(exe_is_load_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] s, input logic [31:0] rf);
    if (s == 5'd0) return rf;
    if (m_valid && m_wen && !m_ld && m_rd == s) return alu_result;
    if (mem_wen && mem_rd == s) return mem_data;
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_sel_pc = 0; m_wen = 0; m_ld = 0; m_opc = 0;
    m_pc = 0; m_reg1 = 0; m_src2 = 0; m_sd = 0; m_rd = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(exe_valid_r), 32'(m_valid));
    chk({tag, ".wen"}, 32'(exe_wen_r), 32'(m_wen));
    chk({tag, ".is_load"}, 32'(exe_is_load_r), 32'(m_ld));
    if (m_valid) begin
      chk({tag, ".opc"}, 32'(exe_alu_opc_r), 32'(m_opc));
      chk({tag, ".sel_pc"}, 32'(exe_sel_pc_r), 32'(m_sel_pc));
      chk({tag, ".pc"}, exe_pc_r, m_pc);
      chk({tag, ".reg1"}, exe_reg1_r, m_reg1);
      chk({tag, ".src2"}, exe_src2_r, m_src2);
      chk({tag, ".store_data"}, exe_store_data_r, m_sd);
      chk({tag, ".rd"}, 32'(exe_rd_r), 32'(m_rd));
    end
  endtask

  // One cycle: check the stall mid-cycle, clock, advance the model, compare the register.
  task automatic step(input string tag);
    logic [31:0] f1, f2;
    logic        lu;
    #3;
    f1 = fwd(dec_rs1, dec_rs1_data);
    f2 = fwd(dec_rs2, dec_rs2_data);
    lu = dec_valid && m_valid && m_ld && m_wen && m_rd != 0 &&
         (m_rd == dec_rs1 || (!dec_sel_imm && m_rd == dec_rs2));
    chk({tag, ".dec_stall"}, 32'(dec_stall), 32'(hold | lu));
    @(posedge clk);
    if (flush || (!hold && lu)) begin
      m_valid = 0; m_wen = 0; m_ld = 0;
    end else if (!hold) begin
      m_valid = dec_valid; m_opc = dec_alu_opc; m_sel_pc = dec_sel_pc; m_pc = dec_pc;
      m_reg1 = f1; m_src2 = dec_sel_imm ? dec_imm : f2; m_sd = f2; m_rd = dec_rd;
      m_wen = dec_wen && dec_valid; m_ld = dec_is_load && dec_valid;
    end
    #1;
    check_all(tag);
  endtask

  task automatic set_instr(input logic [3:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic ld, input logic sel_imm);
    dec_valid = 1; dec_alu_opc = opc; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
    dec_is_load = ld; dec_wen = 1; dec_sel_imm = sel_imm; dec_sel_pc = 0;
    dec_pc = dec_pc + 32'd4;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, 32'(exe_valid_r), 0);
    chk({tag, ".opc"}, 32'(exe_alu_opc_r), 0);
    chk({tag, ".sel_pc"}, 32'(exe_sel_pc_r), 0);
    chk({tag, ".pc"}, exe_pc_r, 0);
    chk({tag, ".reg1"}, exe_reg1_r, 0);
    chk({tag, ".src2"}, exe_src2_r, 0);
    chk({tag, ".store_data"}, exe_store_data_r, 0);
    chk({tag, ".rd"}, 32'(exe_rd_r), 0);
    chk({tag, ".wen"}, 32'(exe_wen_r), 0);
    chk({tag, ".is_load"}, 32'(exe_is_load_r), 0);
  endtask

  initial begin
    logic [31:0] saved_pc;
    rst_n = 0; dec_valid = 0; dec_alu_opc = 0; dec_sel_pc = 0; dec_sel_imm = 0;
    dec_is_load = 0; dec_wen = 0; dec_pc = 32'h100; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    dec_rs1_data = 0; dec_rs2_data = 0; dec_imm = 0; alu_result = 0; mem_rd = 0;
    mem_wen = 0; mem_data = 0; hold = 0; flush = 0;
    model_reset();
    #1;
    check_zero("reset");
    #1 rst_n = 1;
    @(posedge clk); #1;

    // EXE forwarding beats MEM forwarding for the same register
    set_instr(4'b0000, 5'd1, 5'd2, 5'd5, 0, 0);
    step("alu_rd5");
    set_instr(4'b1000, 5'd5, 5'd3, 5'd6, 0, 0);
    alu_result = 32'h10; dec_rs1_data = 32'h99; mem_rd = 5; mem_wen = 1; mem_data = 32'h20;
    step("exe_fwd");
    chk("exe_fwd_value", exe_reg1_r, 32'h10);

    // x0 is never forwarded
    set_instr(4'b0111, 5'd1, 5'd2, 5'd0, 0, 0);
    step("alu_rd0");
    set_instr(4'b0110, 5'd0, 5'd2, 5'd8, 0, 0);
    dec_rs1_data = 32'h77; alu_result = 32'h33; mem_rd = 0; mem_wen = 1;
    step("x0");
    chk("x0_value", exe_reg1_r, 32'h77);

    // Load-use: one bubble, then the load data arrives through the MEM path
    mem_wen = 0;
    set_instr(4'b0000, 5'd1, 5'd0, 5'd7, 1, 1);
    step("load_rd7");
    set_instr(4'b0000, 5'd3, 5'd7, 5'd9, 0, 0);
    dec_rs2_data = 32'h1111;
    step("lu_stall");
    chk("lu_bubble_valid", 32'(exe_valid_r), 0);
    mem_rd = 7; mem_wen = 1; mem_data = 32'hABCD;
    step("lu_fwd");
    chk("lu_fwd_value", exe_src2_r, 32'hABCD);
    mem_wen = 0;

    // Hold freezes the register for three cycles; flush wins over hold
    saved_pc = exe_pc_r;
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_instr(4'b0100, 5'd4, 5'd4, 5'd4, 0, 0);
      step("hold");
    end
    chk("hold_pc", exe_pc_r, saved_pc);
    chk("hold_stall", 32'(dec_stall), 1);
    flush = 1;
    step("hold_flush");
    chk("hold_flush_valid", 32'(exe_valid_r), 0);
    hold = 0; flush = 0;

    // Immediate as second operand, store data still carries forwarded rs2
    set_instr(4'b0000, 5'd1, 5'd2, 5'd9, 0, 0);
    step("alu_rd9");
    set_instr(4'b0000, 5'd1, 5'd9, 5'd10, 0, 1);
    dec_imm = 32'hFFFF_FFFC; alu_result = 32'h55; dec_rs2_data = 32'h2;
    step("imm");
    chk("imm_src2", exe_src2_r, 32'hFFFF_FFFC);
    chk("imm_store_data", exe_store_data_r, 32'h55);

    // Reset while valid: outputs clear with no clock edge
    chk("pre_reset_valid", 32'(exe_valid_r), 1);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_zero("midreset");
    #1 rst_n = 1;

    // Random traffic on a small register window to provoke frequent hazards
    for (int i = 0; i < 3000; i++) begin
      dec_valid    = ($urandom_range(0, 99) < 85);
      dec_alu_opc  = 4'($urandom);
      dec_sel_pc   = 1'($urandom);
      dec_sel_imm  = 1'($urandom);
      dec_is_load  = ($urandom_range(0, 99) < 30);
      dec_wen      = ($urandom_range(0, 99) < 80);
      dec_pc       = $urandom;
      dec_rs1      = 5'($urandom_range(0, 7));
      dec_rs2      = 5'($urandom_range(0, 7));
      dec_rd       = 5'($urandom_range(0, 7));
      dec_rs1_data = $urandom;
      dec_rs2_data = $urandom;
      dec_imm      = $urandom;
      alu_result   = $urandom;
      mem_rd       = 5'($urandom_range(0, 7));
      mem_wen      = 1'($urandom);
      mem_data     = $urandom;
      hold         = ($urandom_range(0, 99) < 10);
      flush        = ($urandom_range(0, 99) < 8);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
